// File: rtl/legv8_ctrl_pkg.sv
// Shared encodings for the LEGv8 multi-cycle control sequencer: opcodes,
// FSM states, ALU operation codes, branch conditions and instruction classes.
package legv8_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM       = 3'd3,
        ST_WRITEBACK = 3'd4
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_ORR   = 4'd3,
        ALU_LSL   = 4'd4,
        ALU_PASSB = 4'd15
    } alu_op_e;

    typedef enum logic [3:0] {
        I_ADDI, I_SUBI, I_SUBIS, I_LDUR, I_STUR, I_LSL,
        I_ADD, I_SUB, I_AND, I_ORR, I_B, I_BCOND, I_ILLEGAL
    } iclass_e;

    localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI  = 10'b1101000100;
    localparam logic [9:0]  OP_SUBIS = 10'b1111000100;
    localparam logic [10:0] OP_LDUR  = 11'b11111000010;
    localparam logic [10:0] OP_STUR  = 11'b11111000000;
    localparam logic [10:0] OP_LSL   = 11'b11010011011;
    localparam logic [10:0] OP_ADD   = 11'b10001011000;
    localparam logic [10:0] OP_SUB   = 11'b11001011000;
    localparam logic [10:0] OP_AND   = 11'b10001010000;
    localparam logic [10:0] OP_ORR   = 11'b10101010000;
    localparam logic [5:0]  OP_B     = 6'b000101;
    localparam logic [7:0]  OP_BCOND = 8'b01010100;

    localparam logic [4:0]  XZR = 5'd31;

    localparam logic [3:0] COND_EQ = 4'd0,  COND_NE = 4'd1,  COND_HS = 4'd2,  COND_LO = 4'd3;
    localparam logic [3:0] COND_MI = 4'd4,  COND_PL = 4'd5,  COND_VS = 4'd6,  COND_VC = 4'd7;
    localparam logic [3:0] COND_HI = 4'd8,  COND_LS = 4'd9,  COND_GE = 4'd10, COND_LT = 4'd11;
    localparam logic [3:0] COND_GT = 4'd12, COND_LE = 4'd13, COND_AL = 4'd14, COND_NV = 4'd15;

    function automatic iclass_e decode_class(input logic [31:0] ir);
        iclass_e c;
        c = I_ILLEGAL;
        if      (ir[31:22] == OP_ADDI)  c = I_ADDI;
        else if (ir[31:22] == OP_SUBI)  c = I_SUBI;
        else if (ir[31:22] == OP_SUBIS) c = I_SUBIS;
        else if (ir[31:21] == OP_LDUR)  c = I_LDUR;
        else if (ir[31:21] == OP_STUR)  c = I_STUR;
        else if (ir[31:21] == OP_LSL)   c = I_LSL;
        else if (ir[31:21] == OP_ADD)   c = I_ADD;
        else if (ir[31:21] == OP_SUB)   c = I_SUB;
        else if (ir[31:21] == OP_AND)   c = I_AND;
        else if (ir[31:21] == OP_ORR)   c = I_ORR;
        else if (ir[31:26] == OP_B)     c = I_B;
        else if (ir[31:24] == OP_BCOND) c = I_BCOND;
        return c;
    endfunction

    // Odd codes are the complement of the even code below them, except AL/NV.
    function automatic logic cond_true(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v, base;
        {n, z, c, v} = nzcv;
        case (cond)
            COND_EQ, COND_NE: base = z;
            COND_HS, COND_LO: base = c;
            COND_MI, COND_PL: base = n;
            COND_VS, COND_VC: base = v;
            COND_HI, COND_LS: base = c & ~z;
            COND_GE, COND_LT: base = (n == v);
            COND_GT, COND_LE: base = ~z & (n == v);
            default:          base = 1'b1;
        endcase
        return (cond[0] && cond != COND_NV) ? ~base : base;
    endfunction

endpackage

// File: rtl/legv8_imm_gen.sv
// Immediate (K) extraction for each LEGv8 instruction format, sign- or
// zero-extended to the datapath width.
module legv8_imm_gen
    import legv8_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [25:0]           ir_i,
    input  iclass_e               iclass_i,
    output logic [DATA_WIDTH-1:0] k_o
);

    always_comb begin
        k_o = '0;
        case (iclass_i)
            I_ADDI, I_SUBI, I_SUBIS: k_o = {{(DATA_WIDTH-12){1'b0}}, ir_i[21:10]};
            I_LDUR, I_STUR:          k_o = {{(DATA_WIDTH-9){ir_i[20]}}, ir_i[20:12]};
            I_LSL:                   k_o = {{(DATA_WIDTH-6){1'b0}}, ir_i[15:10]};
            I_B:                     k_o = {{(DATA_WIDTH-26){ir_i[25]}}, ir_i[25:0]};
            I_BCOND:                 k_o = {{(DATA_WIDTH-19){ir_i[23]}}, ir_i[23:5]};
            default:                 k_o = '0;
        endcase
    end

endmodule

// File: rtl/legv8_multicycle_control.sv
// Multi-cycle LEGv8 control sequencer: fetch/decode/execute/memory/writeback
// FSM with memory handshakes, a data-memory timeout and a registered NZCV.
module legv8_multicycle_control
    import legv8_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  instr_req,
    input  logic                  instr_ready,
    input  logic [31:0]           instr_data,
    input  logic [3:0]            alu_status,
    output logic                  dmem_req,
    output logic                  dmem_we,
    input  logic                  dmem_ready,
    output logic                  ir_load,
    output logic                  rf_we,
    output logic [4:0]            rf_wa,
    output logic [4:0]            rf_ra,
    output logic [4:0]            rf_rb,
    output logic [3:0]            alu_op,
    output logic                  alu_b_is_k,
    output logic                  wb_from_mem,
    output logic                  pc_inc,
    output logic                  pc_branch,
    output logic [DATA_WIDTH-1:0] k,
    output logic [3:0]            flags_q,
    output logic                  illegal,
    output logic                  bus_error,
    output logic [2:0]            state
);

    localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    state_e                state_q;
    logic [31:0]           ir_q;
    logic [TW-1:0]         tmo_q;
    logic [4:0]            rf_wa_q, rf_ra_q, rf_rb_q;
    alu_op_e               alu_op_q;
    logic                  b_is_k_q;
    logic [DATA_WIDTH-1:0] k_q;
    logic [3:0]            nzcv_q;

    iclass_e               cls;
    logic [DATA_WIDTH-1:0] imm;
    alu_op_e               alu_op_d;
    logic                  b_is_k_d;
    logic [4:0]            rf_rb_d;
    logic                  is_alu, wb_ok, cond_ok, tmo_hit;

    // The IR stays valid until the next fetch, so the class is re-derived from it in every state.
    assign cls     = decode_class(ir_q);
    assign is_alu  = cls inside {I_ADDI, I_SUBI, I_SUBIS, I_LSL, I_ADD, I_SUB, I_AND, I_ORR};
    assign wb_ok   = (rf_wa_q != XZR);
    assign cond_ok = cond_true(ir_q[3:0], nzcv_q);
    assign tmo_hit = (MEM_TIMEOUT != 0) && (tmo_q == TW'(MEM_TIMEOUT - 1));

    legv8_imm_gen #(.DATA_WIDTH(DATA_WIDTH)) u_imm_gen (
        .ir_i     (ir_q[25:0]),
        .iclass_i (cls),
        .k_o      (imm)
    );

    always_comb begin
        alu_op_d = ALU_ADD;
        b_is_k_d = 1'b1;
        rf_rb_d  = (cls == I_STUR) ? ir_q[4:0] : ir_q[20:16];
        case (cls)
            I_SUBI, I_SUBIS, I_SUB: alu_op_d = ALU_SUB;
            I_AND:                  alu_op_d = ALU_AND;
            I_ORR:                  alu_op_d = ALU_ORR;
            I_LSL:                  alu_op_d = ALU_LSL;
            I_B, I_BCOND:           alu_op_d = ALU_PASSB;
            default:                alu_op_d = ALU_ADD;
        endcase
        if (cls inside {I_ADD, I_SUB, I_AND, I_ORR}) b_is_k_d = 1'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_FETCH;
            ir_q     <= '0;
            tmo_q    <= '0;
            rf_wa_q  <= '0;
            rf_ra_q  <= '0;
            rf_rb_q  <= '0;
            alu_op_q <= ALU_ADD;
            b_is_k_q <= 1'b0;
            k_q      <= '0;
            nzcv_q   <= '0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (instr_ready) begin
                        ir_q    <= instr_data;
                        state_q <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (cls == I_ILLEGAL) begin
                        state_q <= ST_FETCH;
                    end else begin
                        rf_wa_q  <= ir_q[4:0];
                        rf_ra_q  <= ir_q[9:5];
                        rf_rb_q  <= rf_rb_d;
                        alu_op_q <= alu_op_d;
                        b_is_k_q <= b_is_k_d;
                        k_q      <= imm;
                        state_q  <= ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    if (cls == I_SUBIS) nzcv_q <= alu_status;
                    tmo_q   <= '0;
                    state_q <= (cls inside {I_LDUR, I_STUR}) ? ST_MEM : ST_FETCH;
                end
                ST_MEM: begin
                    // A ready arriving in the timeout cycle still completes the access.
                    if (dmem_ready)
                        state_q <= (cls == I_STUR) ? ST_FETCH : ST_WRITEBACK;
                    else if (tmo_hit)
                        state_q <= ST_FETCH;
                    else if (MEM_TIMEOUT != 0)
                        tmo_q <= tmo_q + 1'b1;
                end
                ST_WRITEBACK: state_q <= ST_FETCH;
                default:      state_q <= ST_FETCH;
            endcase
        end
    end

    always_comb begin
        instr_req   = 1'b0;
        ir_load     = 1'b0;
        illegal     = 1'b0;
        rf_we       = 1'b0;
        wb_from_mem = 1'b0;
        pc_inc      = 1'b0;
        pc_branch   = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        bus_error   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                instr_req = 1'b1;
                ir_load   = instr_ready;
            end
            ST_DECODE: begin
                illegal = (cls == I_ILLEGAL);
                pc_inc  = (cls == I_ILLEGAL);
            end
            ST_EXECUTE: begin
                if (is_alu) begin
                    rf_we  = wb_ok;
                    pc_inc = 1'b1;
                end else if (cls == I_B) begin
                    pc_branch = 1'b1;
                end else if (cls == I_BCOND) begin
                    pc_branch = cond_ok;
                    pc_inc    = ~cond_ok;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cls == I_STUR);
                if (dmem_ready) begin
                    pc_inc = (cls == I_STUR);
                end else if (tmo_hit) begin
                    bus_error = 1'b1;
                    pc_inc    = 1'b1;
                end
            end
            ST_WRITEBACK: begin
                rf_we       = wb_ok;
                wb_from_mem = 1'b1;
                pc_inc      = 1'b1;
            end
            default: ;
        endcase
    end

    assign rf_wa      = rf_wa_q;
    assign rf_ra      = rf_ra_q;
    assign rf_rb      = rf_rb_q;
    assign alu_op     = alu_op_q;
    assign alu_b_is_k = b_is_k_q;
    assign k          = k_q;
    assign flags_q    = nzcv_q;
    assign state      = state_q;

endmodule
